// File: rtl/jhash_stream_feeder.sv
// ---------------------------------------------------------------------------
// jhash_stream_feeder
//
// Transmit side of the jhash core's stream interface. Key words arrive one
// at a time over a valid/ready handshake, are packed into 3-word groups and
// presented to the core on stream_data0/1/2 with stream_valid/stream_ack.
// The final group of a key carries its word count on stream_left. After that
// group is consumed, stream_done is held high until the core raises
// hash_done. The hash is then captured into result and announced with a
// one-cycle result_valid pulse.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_data/in_valid/in_last/in_ready
//                     key word input (transfer = in_valid & in_ready)
//   stream_data0..2   presented group words
//   stream_valid      group presented; held stable until stream_ack
//   stream_ack        core consumed the presented group
//   stream_left       word count of the final group (1..3), 0 otherwise
//   stream_done       final group consumed, hash in progress
//   hash_in/hash_done core hash result and completion level
//   result            captured hash
//   result_valid      one-cycle pulse when result updates
//   busy              a key is in flight
//   group_count       groups acked in the current key (saturating)
// ---------------------------------------------------------------------------
module jhash_stream_feeder #(
    parameter int GRP_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [31:0]          stream_data0,
    output logic [31:0]          stream_data1,
    output logic [31:0]          stream_data2,
    output logic                 stream_valid,
    input  logic                 stream_ack,
    output logic [1:0]           stream_left,
    output logic                 stream_done,
    input  logic [31:0]          hash_in,
    input  logic                 hash_done,
    output logic [31:0]          result,
    output logic                 result_valid,
    output logic                 busy,
    output logic [GRP_CNT_W-1:0] group_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state_reg;

    // Pack buffer: words are written at index pack_cnt_reg. pack_full_reg
    // marks a complete group that could not move to the output register yet.
    logic [31:0] pack_buf_reg [3];
    logic [1:0]  pack_cnt_reg;
    logic        pack_full_reg;
    logic        pack_last_reg;

    // Set once the word carrying in_last has been accepted. Input is held
    // off from then until the hash completes, so words of the next key can
    // never mix into the tail of the current one.
    logic        last_taken_reg;

    // Output register presented to the core.
    logic [31:0] out_data_reg [3];
    logic        out_valid_reg;
    logic [1:0]  out_left_reg;
    logic        out_last_reg;

    logic                 stream_done_reg;
    logic [31:0]          result_reg;
    logic                 result_valid_reg;
    logic [GRP_CNT_W-1:0] group_count_reg;

    // Combinational view of the group as it will look after this cycle's
    // accepted word (if any) is folded in. A group that completes in this
    // cycle can be transferred immediately, giving one-cycle latency from
    // the completing word to stream_valid.
    logic        in_ready_int;
    logic        accept;
    logic        ack_eff;
    logic        out_free;
    logic        grp_complete;
    logic        grp_last;
    logic [1:0]  grp_cnt;
    logic        xfer;
    logic [31:0] grp_word [3];

    assign in_ready_int = !pack_full_reg && (state_reg != S_WAIT) && !last_taken_reg;
    assign accept       = in_valid && in_ready_int;

    // stream_ack only counts while a group is actually presented.
    assign ack_eff      = out_valid_reg && stream_ack;
    assign out_free     = !out_valid_reg || stream_ack;

    assign grp_cnt      = pack_cnt_reg + {1'b0, accept};
    assign grp_last     = pack_last_reg || (accept && in_last);
    assign grp_complete = pack_full_reg || (accept && ((pack_cnt_reg == 2'd2) || in_last));
    assign xfer         = grp_complete && out_free;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_word
            // Bypass the accepted word into the slot it is about to occupy.
            assign grp_word[gi] = (accept && (pack_cnt_reg == 2'(gi))) ? in_data
                                                                        : pack_buf_reg[gi];

            // Slots are cleared on transfer, so unfilled words of a short
            // final group are always zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pack_buf_reg[gi] <= 32'd0;
                end else if (xfer) begin
                    pack_buf_reg[gi] <= 32'd0;
                end else if (accept && (pack_cnt_reg == 2'(gi))) begin
                    pack_buf_reg[gi] <= in_data;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_data_reg[gi] <= 32'd0;
                end else if (xfer) begin
                    out_data_reg[gi] <= grp_word[gi];
                end
            end
        end
    endgenerate

    // Pack buffer control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_cnt_reg  <= 2'd0;
            pack_full_reg <= 1'b0;
            pack_last_reg <= 1'b0;
        end else if (xfer) begin
            pack_cnt_reg  <= 2'd0;
            pack_full_reg <= 1'b0;
            pack_last_reg <= 1'b0;
        end else if (accept) begin
            pack_cnt_reg  <= grp_cnt;
            pack_last_reg <= grp_last;
            if (grp_complete) begin
                pack_full_reg <= 1'b1;
            end
        end
    end

    // Output register control. Data and stream_left are only loaded on a
    // transfer, so they stay stable while a group waits for its ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_left_reg  <= 2'd0;
            out_last_reg  <= 1'b0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_left_reg  <= grp_last ? grp_cnt : 2'd0;
            out_last_reg  <= grp_last;
        end else if (ack_eff) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Message FSM, done/result handshake and group counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            stream_done_reg  <= 1'b0;
            result_reg       <= 32'd0;
            result_valid_reg <= 1'b0;
            group_count_reg  <= '0;
            last_taken_reg   <= 1'b0;
        end else begin
            result_valid_reg <= 1'b0;

            if (accept && in_last) begin
                last_taken_reg <= 1'b1;
            end

            if (ack_eff && (group_count_reg != {GRP_CNT_W{1'b1}})) begin
                group_count_reg <= group_count_reg + 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        state_reg <= S_FILL;
                    end
                end
                S_FILL: begin
                    // stream_done is raised only after the final group has
                    // been consumed, so it is never seen with an earlier ack.
                    if (ack_eff && out_last_reg) begin
                        state_reg       <= S_WAIT;
                        stream_done_reg <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (hash_done) begin
                        result_reg       <= hash_in;
                        result_valid_reg <= 1'b1;
                        stream_done_reg  <= 1'b0;
                        group_count_reg  <= '0;
                        last_taken_reg   <= 1'b0;
                        state_reg        <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_int;
    assign stream_data0 = out_data_reg[0];
    assign stream_data1 = out_data_reg[1];
    assign stream_data2 = out_data_reg[2];
    assign stream_valid = out_valid_reg;
    assign stream_left  = out_left_reg;
    assign stream_done  = stream_done_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign busy         = (state_reg != S_IDLE);
    assign group_count  = group_count_reg;

endmodule
